// File: rtl/timer_sched.sv
// timer_sched: programmable periodic / one-shot tick generator with pause, stop and a square-wave output.
// Optional clock prescaler is compiled in when TIMER_SCHED_PRESCALE_EN is defined.
module timer_sched #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_PERIOD = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] period_i,
    input  logic             oneshot_i,
`ifdef TIMER_SCHED_PRESCALE_EN
    input  logic [7:0]       presc_i,
`endif
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             tick,
    output logic             sq_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic             r_oneshot;
    logic             r_sq;
    logic             r_tick;
    logic             r_cfg_err;

    logic             w_stopped;
    logic             w_cfg_acc;
    logic             w_launch;
    logic             w_run_ok;
    logic             w_presc_hit;
    logic             w_step;
    logic             w_wrap;

    // A configuration write is only safe while no run is in progress.
    assign w_stopped = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_cfg_acc = cfg_we && w_stopped && (period_i != '0);

    // Strobes resolve as stop > pause > start; a lower strobe is dropped when a higher one is present.
    assign w_launch  = start && !stop && !pause && w_stopped;
    assign w_run_ok  = (r_state == S_RUN) && !stop && !pause;
    assign w_step    = w_run_ok && w_presc_hit;
    assign w_wrap    = w_step && (r_count >= (r_period - CNT_W'(1)));

`ifdef TIMER_SCHED_PRESCALE_EN
    logic [7:0] r_presc;
    logic [7:0] r_pcnt;

    assign w_presc_hit = (r_pcnt == r_presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= 8'd0;
            r_pcnt  <= 8'd0;
        end else begin
            if (w_cfg_acc) begin
                r_presc <= presc_i;
            end
            if (stop || w_launch) begin
                r_pcnt <= 8'd0;
            end else if (w_run_ok) begin
                r_pcnt <= w_presc_hit ? 8'd0 : r_pcnt + 8'd1;
            end
        end
    end
`else
    assign w_presc_hit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (pause) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else if (start && (r_state != S_RUN)) begin
            w_state_nxt = S_RUN;
        end else if (w_wrap && r_oneshot) begin
            w_state_nxt = S_DONE;
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN,
            S_PAUSE: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Counter, square wave and the registered tick / error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_period  <= CNT_W'(RST_PERIOD);
            r_oneshot <= 1'b0;
            r_sq      <= 1'b0;
            r_tick    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_tick    <= w_wrap;
            r_cfg_err <= cfg_we && !w_cfg_acc;
            if (w_cfg_acc) begin
                r_period  <= period_i;
                r_oneshot <= oneshot_i;
            end
            if (stop) begin
                r_count <= '0;
                r_sq    <= 1'b0;
            end else if (w_launch) begin
                r_count <= '0;
            end else if (w_step) begin
                if (w_wrap) begin
                    r_count <= '0;
                    r_sq    <= ~r_sq;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign tick    = r_tick;
    assign sq_out  = r_sq;
    assign cfg_err = r_cfg_err;
    assign count_o = r_count;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed scenarios plus random strobes, scored against a behavioural timer model.
module tb_timer_sched;

    localparam int CNT_W = 16;
    localparam int RSTP  = 20;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [CNT_W-1:0] period_i;
    logic             oneshot_i;
    logic             start;
    logic             pause;
    logic             stop;
    logic             tick;
    logic             sq_out;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] count_o;

    typedef struct {
        bit tick;
        bit sq;
        bit busy;
        bit done;
        bit err;
        int cnt;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks  = 0;
    int n_errs   = 0;

    int m_state;
    int m_cnt;
    int m_per;
    bit m_os;
    bit m_sq;

    timer_sched #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RSTP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .period_i  (period_i),
        .oneshot_i (oneshot_i),
`ifdef TIMER_SCHED_PRESCALE_EN
        .presc_i   (8'd0),
`endif
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .tick      (tick),
        .sq_out    (sq_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    // Reference: what the timer should look like after the coming edge, given these inputs.
    task automatic model(input bit r, input bit c, input int p, input bit o,
                         input bit s, input bit pa, input bit sp, output exp_t e);
        bit tk;
        bit err;
        bit acc;
        tk  = 0;
        err = 0;
        if (r) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_per   = RSTP;
            m_os    = 0;
            m_sq    = 0;
        end else begin
            acc = c && (m_state == M_IDLE || m_state == M_DONE) && (p != 0);
            err = c && !acc;
            if (sp) begin
                m_state = M_IDLE;
                m_cnt   = 0;
                m_sq    = 0;
            end else if (pa) begin
                if (m_state == M_RUN) m_state = M_PAUSE;
            end else if (s && m_state != M_RUN) begin
                if (m_state != M_PAUSE) m_cnt = 0;
                m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                m_cnt = m_cnt + 1;
                if (m_cnt >= m_per) begin
                    m_cnt = 0;
                    tk    = 1;
                    m_sq  = !m_sq;
                    if (m_os) m_state = M_DONE;
                end
            end
            if (acc) begin
                m_per = p;
                m_os  = o;
            end
        end
        e.tick = tk;
        e.sq   = m_sq;
        e.busy = (m_state == M_RUN) || (m_state == M_PAUSE);
        e.done = (m_state == M_DONE);
        e.err  = err;
        e.cnt  = m_cnt;
    endtask

    task automatic cyc(input bit r, input bit c, input int p, input bit o,
                       input bit s, input bit pa, input bit sp);
        exp_t e;
        rst       = r;
        cfg_we    = c;
        period_i  = CNT_W'(p);
        oneshot_i = o;
        start     = s;
        pause     = pa;
        stop      = sp;
        model(r, c, p, o, s, pa, sp, e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (tick !== e.tick || sq_out !== e.sq || busy !== e.busy ||
                    done !== e.done || cfg_err !== e.err || count_o !== CNT_W'(e.cnt)) begin
                    n_errors++;
                    $display("FAIL outputs @%0t: tick/sq/busy/done/err/count got %b%b%b%b%b/%0d required %b%b%b%b%b/%0d",
                             $time, tick, sq_out, busy, done, cfg_err, count_o,
                             e.tick, e.sq, e.busy, e.done, e.err, e.cnt);
                end
                if (tick === 1'b1) n_ticks++;
                if (cfg_err === 1'b1) n_errs++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst = 1'b1; cfg_we = 1'b0; period_i = '0; oneshot_i = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 1);
        idle(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(count_o), 0);

        // Periodic, period 4.
        cyc(0, 1, 4, 0, 0, 0, 0);
        n_ticks = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(19);
        chk("period4_ticks", n_ticks, 4);
        chk("period4_busy", int'(busy), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // One-shot, period 3, twice.
        cyc(0, 1, 3, 1, 0, 0, 0);
        n_ticks = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(8);
        chk("oneshot_ticks1", n_ticks, 1);
        chk("oneshot_done", int'(done), 1);
        chk("oneshot_busy", int'(busy), 0);
        chk("oneshot_count", int'(count_o), 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(8);
        chk("oneshot_ticks2", n_ticks, 2);

        // Pause at count 5 for 7 cycles, then resume.
        cyc(0, 1, 10, 0, 0, 0, 0);
        n_ticks = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(5);
        chk("pause_at5", int'(count_o), 5);
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle(6);
        chk("paused_count", int'(count_o), 5);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(4);
        chk("resume_no_tick", n_ticks, 0);
        idle(1);
        chk("resume_tick", n_ticks, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Rejected configuration writes.
        n_errs = 0;
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 0, 0, 0, 0);
        n_ticks = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 8, 0, 0, 0, 0);
        chk("cfg_err_pulses", n_errs, 2);
        idle(9);
        chk("period_kept_ticks", n_ticks, 2);

        // Simultaneous stop/pause/start, then reset mid-run.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 3, 0, 1, 0, 0);
        idle(4);
        chk("sq_high_before_stop", int'(sq_out), 1);
        cyc(0, 0, 0, 0, 1, 1, 1);
        chk("triple_busy", int'(busy), 0);
        chk("triple_sq", int'(sq_out), 0);
        chk("triple_count", int'(count_o), 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("rst_busy", int'(busy), 0);
        n_ticks = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(RSTP - 1);
        chk("rst_period_no_tick", n_ticks, 0);
        idle(1);
        chk("rst_period_tick", n_ticks, 1);

        // Random strobes and configuration.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(499, 0) == 0),
                ($urandom_range(9, 0) == 0),
                int'($urandom_range(9, 0)),
                $urandom_range(1, 0) == 1,
                ($urandom_range(7, 0) == 0),
                ($urandom_range(15, 0) == 0),
                ($urandom_range(39, 0) == 0));
        end
        idle(2);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
